// File: rtl/uart_image_loader_pkg.sv
// Shared constants for the UART image loader: FSM state encodings and baud default.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_image_loader_pkg;

  // 50 MHz core clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // 8N1 receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Loader states
  localparam logic [1:0] L_IDLE = 2'd0;
  localparam logic [1:0] L_LOAD = 2'd1;
  localparam logic [1:0] L_DONE = 2'd2;

endpackage

// File: rtl/uart_image_loader_uart_rx.sv
// 8N1 UART receiver with 2-flop synchroniser and start-bit glitch rejection.
// Latency: rx_valid pulses the cycle after the stop-bit sample.
// Backpressure: none; rx_valid is a one-cycle pulse the consumer must take.
// Ports: clk, reset (sync, active-high), rx (async line, idle high),
//        rx_valid (1-cycle strobe), rx_byte (received byte),
//        rx_frame_err (1-cycle strobe when the stop bit is low).
module uart_rx
  import uart_image_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1, r_sync2, r_sync_d;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_stop_wait;
  logic          r_valid;
  logic          r_ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_d    <= 1'b1;
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_stop_wait <= 1'b0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_sync1  <= rx;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          // falling edge of the synchronised line marks a candidate start bit
          if (r_sync_d && !r_sync2) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!r_sync2) begin
              r_state   <= RX_DATA;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= RX_IDLE;  // line bounced back high: glitch
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            // LSB arrives first, so shift in from the top
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_stop_wait) begin
            // after a framing error, hold off until the line idles high
            // so a long break is not mistaken for a new start bit
            if (r_sync2) begin
              r_stop_wait <= 1'b0;
              r_state     <= RX_IDLE;
            end
          end else if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_valid <= 1'b1;
              r_state <= RX_IDLE;
            end else begin
              r_ferr      <= 1'b1;
              r_stop_wait <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_valid     = r_valid;
  assign rx_byte      = r_shift;
  assign rx_frame_err = r_ferr;

endmodule

// File: rtl/uart_image_loader.sv
// Loads IMAGE_BYTES bytes from a UART stream into data memory starting at BASE_ADDR.
// Latency: each received byte is written the cycle after the receiver strobes it.
// Backpressure: none; memory must accept one write per cycle when mem_wren is high.
// Ports: clk, reset (sync, active-high), start (arm pulse), rx (UART line),
//        mem_wren/mem_address/mem_data (write port), busy, load_done,
//        frame_error (sticky until start/reset), byte_count (bytes written).
module uart_image_loader
  import uart_image_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int          IMAGE_BYTES  = 65536,
  parameter logic [15:0] BASE_ADDR    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx,
  output logic        mem_wren,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        busy,
  output logic        load_done,
  output logic        frame_error,
  output logic [16:0] byte_count
);

  localparam logic [16:0] IMAGE_COUNT = 17'(IMAGE_BYTES);

  logic        w_rx_valid;
  logic [7:0]  w_rx_byte;
  logic        w_rx_ferr;
  logic [16:0] w_next_count;

  logic [1:0]  r_state;
  logic        r_mem_wren;
  logic [15:0] r_mem_address;
  logic [7:0]  r_mem_data;
  logic [16:0] r_byte_count;
  logic        r_frame_error;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_valid    (w_rx_valid),
    .rx_byte     (w_rx_byte),
    .rx_frame_err(w_rx_ferr)
  );

  assign w_next_count = r_byte_count + 17'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= L_IDLE;
      r_mem_wren    <= 1'b0;
      r_mem_address <= BASE_ADDR;
      r_mem_data    <= 8'h00;
      r_byte_count  <= 17'd0;
      r_frame_error <= 1'b0;
    end else begin
      r_mem_wren <= 1'b0;
      case (r_state)
        L_IDLE, L_DONE: begin
          if (start) begin
            r_state       <= L_LOAD;
            r_byte_count  <= 17'd0;
            r_frame_error <= 1'b0;
          end
        end
        L_LOAD: begin
          if (w_rx_valid) begin
            r_mem_wren    <= 1'b1;
            // 16-bit add wraps FFFF -> 0000 naturally
            r_mem_address <= BASE_ADDR + r_byte_count[15:0];
            r_mem_data    <= w_rx_byte;
            r_byte_count  <= w_next_count;
            if (w_next_count == IMAGE_COUNT) r_state <= L_DONE;
          end
        end
        default: r_state <= L_IDLE;
      endcase
      // a framing error in the same cycle as start still gets recorded
      if (w_rx_ferr) r_frame_error <= 1'b1;
    end
  end

  assign mem_wren    = r_mem_wren;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign byte_count  = r_byte_count;
  assign frame_error = r_frame_error;
  assign busy        = (r_state == L_LOAD);
  assign load_done   = (r_state == L_DONE);

endmodule

// File: tb/tb_uart_image_loader.sv
module tb_uart_image_loader;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_line, rx_line, sel;
  logic start_a, start_b, rx_a, rx_b;
  assign start_a = start_line & ~sel;
  assign start_b = start_line & sel;
  assign rx_a    = sel ? 1'b1 : rx_line;
  assign rx_b    = sel ? rx_line : 1'b1;

  logic        wren_a, busy_a, done_a, ferr_a;
  logic [15:0] addr_a;
  logic [7:0]  data_a;
  logic [16:0] cnt_a;
  logic        wren_b, busy_b, done_b, ferr_b;
  logic [15:0] addr_b;
  logic [7:0]  data_b;
  logic [16:0] cnt_b;

  uart_image_loader #(.CLKS_PER_BIT(CPB), .IMAGE_BYTES(4), .BASE_ADDR(16'h0100)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rx(rx_a),
    .mem_wren(wren_a), .mem_address(addr_a), .mem_data(data_a),
    .busy(busy_a), .load_done(done_a), .frame_error(ferr_a), .byte_count(cnt_a)
  );

  uart_image_loader #(.CLKS_PER_BIT(CPB), .IMAGE_BYTES(4), .BASE_ADDR(16'hFFFE)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rx(rx_b),
    .mem_wren(wren_b), .mem_address(addr_b), .mem_data(data_b),
    .busy(busy_b), .load_done(done_b), .frame_error(ferr_b), .byte_count(cnt_b)
  );

  // write logs: one entry per mem_wren pulse
  logic [15:0] wa_addr[$];
  logic [7:0]  wa_data[$];
  logic [15:0] wb_addr[$];
  logic [7:0]  wb_data[$];

  always @(negedge clk) begin
    if (wren_a === 1'b1) begin wa_addr.push_back(addr_a); wa_data.push_back(data_a); end
    if (wren_b === 1'b1) begin wb_addr.push_back(addr_b); wb_data.push_back(data_b); end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  dat;
    bit          stop_ok;
    bit          exp_wr;
    logic [15:0] exp_addr;
    logic [16:0] exp_count;
    bit          exp_ferr;
    bit          exp_done;
    bit          exp_busy;
  } vec_t;

  task automatic send(input logic [7:0] b, input bit stop_ok);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = stop_ok;
    repeat (CPB) @(negedge clk);
    rx_line = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_line = 1'b1;
    @(negedge clk);
    start_line = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_state(input string nm, input logic [16:0] c, input bit f, input bit d, input bit b);
    chk({nm, "_count"}, sel ? cnt_b  : cnt_a,  c);
    chk({nm, "_ferr"},  sel ? ferr_b : ferr_a, f);
    chk({nm, "_done"},  sel ? done_b : done_a, d);
    chk({nm, "_busy"},  sel ? busy_b : busy_a, b);
  endtask

  function automatic int wr_count();
    return sel ? wb_addr.size() : wa_addr.size();
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int n0, n1;
    n0 = wr_count();
    send(v.dat, v.stop_ok);
    n1 = wr_count();
    chk({nm, "_nwrites"}, n1 - n0, v.exp_wr ? 1 : 0);
    if (v.exp_wr && n1 > n0) begin
      chk({nm, "_addr"}, sel ? wb_addr[n1-1] : wa_addr[n1-1], v.exp_addr);
      chk({nm, "_data"}, sel ? wb_data[n1-1] : wa_data[n1-1], v.dat);
    end
    chk_state(nm, v.exp_count, v.exp_ferr, v.exp_done, v.exp_busy);
  endtask

  vec_t va[6];
  vec_t vb[4];
  vec_t vm[5];

  initial begin
    //          dat    stop  wr    addr      count  ferr  done  busy
    va[0] = '{8'h11, 1'b1, 1'b1, 16'h0100, 17'd1, 1'b0, 1'b0, 1'b1};
    va[1] = '{8'h22, 1'b1, 1'b1, 16'h0101, 17'd2, 1'b0, 1'b0, 1'b1};
    va[2] = '{8'hA5, 1'b0, 1'b0, 16'h0000, 17'd2, 1'b1, 1'b0, 1'b1};
    va[3] = '{8'h33, 1'b1, 1'b1, 16'h0102, 17'd3, 1'b1, 1'b0, 1'b1};
    va[4] = '{8'h44, 1'b1, 1'b1, 16'h0103, 17'd4, 1'b1, 1'b1, 1'b0};
    va[5] = '{8'h55, 1'b1, 1'b0, 16'h0000, 17'd4, 1'b1, 1'b1, 1'b0};
    vb[0] = '{8'h01, 1'b1, 1'b1, 16'hFFFE, 17'd1, 1'b0, 1'b0, 1'b1};
    vb[1] = '{8'h80, 1'b1, 1'b1, 16'hFFFF, 17'd2, 1'b0, 1'b0, 1'b1};
    vb[2] = '{8'hFF, 1'b1, 1'b1, 16'h0000, 17'd3, 1'b0, 1'b0, 1'b1};
    vb[3] = '{8'h00, 1'b1, 1'b1, 16'h0001, 17'd4, 1'b0, 1'b1, 1'b0};
    // reload of A, reset after two bytes, then bytes with no start, then restart
    vm[0] = '{8'h5A, 1'b1, 1'b1, 16'h0100, 17'd1, 1'b0, 1'b0, 1'b1};
    vm[1] = '{8'hC3, 1'b1, 1'b1, 16'h0101, 17'd2, 1'b0, 1'b0, 1'b1};
    vm[2] = '{8'h77, 1'b1, 1'b0, 16'h0000, 17'd0, 1'b0, 1'b0, 1'b0};
    vm[3] = '{8'h78, 1'b1, 1'b0, 16'h0000, 17'd0, 1'b0, 1'b0, 1'b0};
    vm[4] = '{8'h99, 1'b1, 1'b1, 16'h0100, 17'd1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; start_line = 1'b0; rx_line = 1'b1; sel = 1'b0;
    repeat (2) @(negedge clk);

    // reset state, both instances
    chk("rst_wren_a", wren_a, 1'b0);
    chk("rst_addr_a", addr_a, 16'h0100);
    chk("rst_data_a", data_a, 8'h00);
    chk_state("rst_a", 17'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_wren_b", wren_b, 1'b0);
    chk("rst_addr_b", addr_b, 16'hFFFE);
    chk("rst_data_b", data_b, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    pulse_start();
    chk_state("start_a", 17'd0, 1'b0, 1'b0, 1'b1);

    // one-cycle low glitch on the line
    rx_line = 1'b0;
    @(negedge clk);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_nwrites", wa_addr.size(), 0);
    chk_state("glitch", 17'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) run_vec(va[i], $sformatf("a%0d", i));

    sel = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) run_vec(vb[i], $sformatf("b%0d", i));

    sel = 1'b0;
    pulse_start();  // re-arm from L_DONE clears count/done/ferr
    chk_state("rearm_a", 17'd0, 1'b0, 1'b0, 1'b1);
    run_vec(vm[0], "m0");
    run_vec(vm[1], "m1");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_addr", addr_a, 16'h0100);
    chk("midrst_wren", wren_a, 1'b0);
    chk_state("midrst", 17'd0, 1'b0, 1'b0, 1'b0);
    run_vec(vm[2], "m2");
    run_vec(vm[3], "m3");
    pulse_start();
    run_vec(vm[4], "m4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard stop in case stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/uart_image_loader.md
UART_IMAGE_LOADER -- requirements
Module: uart_image_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter IMAGE_BYTES, default 65536, bytes per image load (1..65536).
REQ-003 SHALL have parameter BASE_ADDR, default 16'h0000, data-memory address of first byte.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, arm/re-arm a load, one-cycle pulse.
REQ-008 SHALL have port rx, input, 1, asynchronous UART line, 8N1, idle high.
REQ-009 SHALL have port mem_wren, output, 1, data-memory write enable.
REQ-010 SHALL have port mem_address, output, 16, data-memory address.
REQ-011 SHALL have port mem_data, output, 8, data-memory write byte.
REQ-012 SHALL have ports busy, load_done, frame_error, output, 1 each; byte_count, output, 17, bytes written.

Function
REQ-013 SHALL pass rx through a 2-flop synchroniser before any use.
REQ-014 Receiver FSM SHALL have states RX_IDLE, RX_START, RX_DATA, RX_STOP.
- RX_IDLE->RX_START on synchronised falling edge.
REQ-015 In RX_START the receiver SHALL resample at CLKS_PER_BIT/2.
- low -> RX_DATA.
- high -> glitch, back to RX_IDLE, no output.
REQ-016 RX_DATA SHALL sample 8 bits, LSB first, each CLKS_PER_BIT after the previous sample.
REQ-017 RX_STOP SHALL sample once, CLKS_PER_BIT after bit 7.
- high -> one-cycle rx_valid with the byte.
- low -> byte discarded; frame_error set sticky; wait for line high before RX_IDLE.
REQ-018 Loader FSM SHALL have states L_IDLE, L_LOAD, L_DONE.
- start in L_IDLE or L_DONE -> L_LOAD; clears byte_count, load_done, frame_error.
- start in L_LOAD ignored.
REQ-019 In L_LOAD each rx_valid SHALL cause exactly one write in the following cycle:
- mem_wren=1 for one cycle;
- mem_address=(BASE_ADDR+byte_count) mod 2^16;
- mem_data=received byte.
- byte_count increments in that same cycle.
REQ-020 When byte_count reaches IMAGE_BYTES the loader SHALL enter L_DONE; load_done=1 held until start or reset.
REQ-021 rx_valid in L_IDLE or L_DONE SHALL be discarded with no write and no count change.
REQ-022 busy SHALL be 1 exactly while in L_LOAD.
REQ-023 mem_wren SHALL be 0 in every cycle with no write.
REQ-024 mem_address and mem_data SHALL hold their last values when mem_wren is 0.
REQ-025 Address SHALL wrap from 16'hFFFF to 16'h0000 with no error.

Reset
REQ-026 reset SHALL force RX_IDLE and L_IDLE, overriding start and any in-flight byte, including a load in progress.
- mem_wren, busy, load_done, frame_error = 0;
- byte_count = 0;
- mem_address = BASE_ADDR;
- mem_data = 0;
- synchroniser flops = 1.

Structure
REQ-027 A shared package SHALL hold the state encodings and the default baud constant.
REQ-028 The 8N1 receiver SHALL be sub-module uart_rx (clk, reset, rx, rx_valid, rx_byte); the loader FSM and address counter stay in the top.

Verification (CLKS_PER_BIT=4)
REQ-029 Reset: assert reset 2 cycles -> all outputs 0, mem_address=BASE_ADDR.
REQ-030 Normal load: BASE_ADDR=16'h0100, IMAGE_BYTES=4, start, send 11,22,33,44.
- 4 writes at 0100..0103 with those data;
- load_done=1 and busy=0 after 4th write.
REQ-031 Bad stop: send 0xA5 with stop bit 0 -> frame_error=1, no mem_wren, byte_count unchanged; next good byte written normally.
REQ-032 Start glitch: rx low for 1 cycle -> no rx_valid, no write.
REQ-033 Wrap: BASE_ADDR=16'hFFFE, IMAGE_BYTES=4 -> writes at FFFE, FFFF, 0000, 0001.
REQ-034 Reset mid-load: reset after 2 of 4 bytes -> L_IDLE, byte_count=0; following bytes not written until start.
